// File: rtl/freq_meter.sv
// Gated edge-counting frequency meter: counts rising edges of i_Signal over GATE_CYCLES clocks.
// Optional sticky saturation flag on o_Ovf enabled by defining FREQ_METER_OVF_EN.
//
// state | meaning
// IDLE  | counters held at 0, waiting for i_En
// GATE  | window open, counting synchronized rising edges
// LATCH | publish count to o_Freq, strobe o_Valid next cycle
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 100_000_000,
    parameter int unsigned CNT_W       = 27
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_En,
    input  logic             i_Signal,
    output logic [CNT_W-1:0] o_Freq,
    output logic             o_Valid,
    output logic             o_Busy,
    output logic             o_Ovf
);

    localparam int unsigned       GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GATE  = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    logic              sync1_q, sync2_q, prev_q;
    logic              sig_edge;
    logic [1:0]        state_q, state_d;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  freq_q, freq_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= i_Signal;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign sig_edge = sync2_q & ~prev_q;

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        cnt_d   = cnt_q;
        freq_d  = freq_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                gate_d = '0;
                cnt_d  = '0;
                if (i_En) state_d = S_GATE;
            end
            S_GATE: begin
                if (!i_En) begin
                    state_d = S_IDLE;
                    gate_d  = '0;
                    cnt_d   = '0;
                end else begin
                    gate_d = gate_q + GATE_ONE;
                    if (sig_edge && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
                    if (gate_q == GATE_LAST) state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                // edge arriving here is dropped: counters restart for the next window
                freq_d  = cnt_q;
                valid_d = 1'b1;
                gate_d  = '0;
                cnt_d   = '0;
                state_d = i_En ? S_GATE : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                gate_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_d = (state_d != S_IDLE);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= S_IDLE;
            gate_q  <= '0;
            cnt_q   <= '0;
            freq_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            cnt_q   <= cnt_d;
            freq_q  <= freq_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

`ifdef FREQ_METER_OVF_EN
    logic sat_q, sat_d;
    logic ovf_q, ovf_d;

    always_comb begin
        sat_d = sat_q;
        ovf_d = ovf_q;
        if (state_q == S_GATE && i_En) begin
            if (sig_edge && (cnt_q == CNT_MAX)) sat_d = 1'b1;
        end else if (state_q == S_LATCH) begin
            ovf_d = sat_q;
            sat_d = 1'b0;
        end else begin
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sat_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
            ovf_q <= ovf_d;
        end
    end

    assign o_Ovf = ovf_q;
`else
    assign o_Ovf = 1'b0;
`endif

    assign o_Freq  = freq_q;
    assign o_Valid = valid_q;
    assign o_Busy  = busy_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a 16-bit instance for counting and a 4-bit instance for saturation.
module tb_freq_meter;

`ifdef FREQ_METER_OVF_EN
    localparam bit EXP_OVF = 1'b1;
`else
    localparam bit EXP_OVF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        sig;
    int          sig_half = 5;
    bit          sig_level = 1'b1;

    logic [15:0] a_freq;
    logic        a_valid, a_busy, a_ovf;
    logic [3:0]  b_freq;
    logic        b_valid, b_busy, b_ovf;

    int n_vec = 0;
    int n_err = 0;

    freq_meter #(.GATE_CYCLES(1000), .CNT_W(16)) dut_a (
        .i_Clk(clk), .i_Rst(rst), .i_En(en), .i_Signal(sig),
        .o_Freq(a_freq), .o_Valid(a_valid), .o_Busy(a_busy), .o_Ovf(a_ovf)
    );

    freq_meter #(.GATE_CYCLES(1000), .CNT_W(4)) dut_b (
        .i_Clk(clk), .i_Rst(rst), .i_En(en), .i_Signal(sig),
        .o_Freq(b_freq), .o_Valid(b_valid), .o_Busy(b_busy), .o_Ovf(b_ovf)
    );

    always #5 clk = ~clk;

    // transitions land on falling clock edges, away from the sampling edge
    initial begin
        forever begin
            if (sig_half == 0) begin
                sig = sig_level;
                #10;
            end else begin
                sig = 1'b1;
                #(sig_half * 10);
                sig = 1'b0;
                #(sig_half * 10);
            end
        end
    end

    task automatic wait_valid(input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (a_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit busy_seen;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (a_freq !== 16'd0 || a_valid !== 1'b0 || a_busy !== 1'b0 || a_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_a: freq=%0d valid=%b busy=%b ovf=%b, want all 0", a_freq, a_valid, a_busy, a_ovf);
        end
        n_vec++;
        if (b_freq !== 4'd0 || b_valid !== 1'b0 || b_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_b: freq=%0d valid=%b ovf=%b, want all 0", b_freq, b_valid, b_ovf);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        busy_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (a_busy !== 1'b0 || a_valid !== 1'b0) busy_seen = 1'b1;
        end
        n_vec++;
        if (busy_seen) begin
            n_err++;
            $display("FAIL reset_idle: busy/valid seen=%b with en=0, want 0", busy_seen);
        end
    endtask

    task automatic test_steady();
        int n;
        bit ok;
        sig_half = 5;
        @(negedge clk);
        en = 1'b1;
        wait_valid(1100, n, ok);
        n_vec++;
        if (!ok || n != 1002) begin
            n_err++;
            $display("FAIL steady_latency: got %0d cycles (ok=%b), want 1002", n, ok);
        end
        n_vec++;
        if (a_freq !== 16'd100) begin
            n_err++;
            $display("FAIL steady_freq: got %0d, want 100", a_freq);
        end
        n_vec++;
        if (b_freq !== 4'd15 || b_ovf !== EXP_OVF) begin
            n_err++;
            $display("FAIL sat_freq_ovf: got freq=%0d ovf=%b, want 15/%b", b_freq, b_ovf, EXP_OVF);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_vec++;
            if (a_valid !== 1'b0) begin
                n_err++;
                $display("FAIL steady_width: valid=%b one cycle after strobe, want 0", a_valid);
            end
            wait_valid(1100, n, ok);
            n_vec++;
            if (!ok || n + 1 != 1001) begin
                n_err++;
                $display("FAIL steady_period: got %0d cycles (ok=%b), want 1001", n + 1, ok);
            end
            n_vec++;
            if (a_freq !== 16'd100) begin
                n_err++;
                $display("FAIL steady_freq_rep: got %0d, want 100", a_freq);
            end
        end
    endtask

    task automatic test_sat_recover();
        int n;
        bit ok;
        sig_half = 100;
        wait_valid(1100, n, ok);
        wait_valid(1100, n, ok);
        n_vec++;
        if (!ok || b_freq !== 4'd5 || b_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL sat_recover: got freq=%0d ovf=%b ok=%b, want 5/0", b_freq, b_ovf, ok);
        end
        n_vec++;
        if (a_freq !== 16'd5) begin
            n_err++;
            $display("FAIL slow_freq: got %0d, want 5", a_freq);
        end
    endtask

    task automatic test_no_activity();
        int n;
        bit ok;
        sig_level = 1'b1;
        sig_half  = 0;
        wait_valid(1100, n, ok);
        wait_valid(1100, n, ok);
        n_vec++;
        if (!ok || a_freq !== 16'd0) begin
            n_err++;
            $display("FAIL idle_freq: got %0d ok=%b, want 0", a_freq, ok);
        end
        wait_valid(1100, n, ok);
        n_vec++;
        if (!ok || n != 1001 || a_freq !== 16'd0) begin
            n_err++;
            $display("FAIL idle_period: got %0d cycles freq=%0d ok=%b, want 1001/0", n, a_freq, ok);
        end
    endtask

    task automatic test_abort();
        int n;
        int strobes;
        bit ok;
        sig_half = 5;
        wait_valid(1100, n, ok);
        wait_valid(1100, n, ok);
        n_vec++;
        if (!ok || a_freq !== 16'd100) begin
            n_err++;
            $display("FAIL abort_pre: got %0d ok=%b, want 100", a_freq, ok);
        end
        repeat (499) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        n_vec++;
        if (a_busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_busy: got %b, want 0", a_busy);
        end
        strobes = 0;
        repeat (1100) begin
            @(negedge clk);
            if (a_valid !== 1'b0) strobes++;
        end
        n_vec++;
        if (strobes != 0 || a_freq !== 16'd100) begin
            n_err++;
            $display("FAIL abort_hold: strobes=%0d freq=%0d, want 0/100", strobes, a_freq);
        end
        en = 1'b1;
        wait_valid(1100, n, ok);
        n_vec++;
        if (!ok || n != 1002 || a_freq !== 16'd100) begin
            n_err++;
            $display("FAIL abort_resume: got %0d cycles freq=%0d ok=%b, want 1002/100", n, a_freq, ok);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit ok;
        int guard;
        wait_valid(1100, n, ok);
        repeat (300) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_freq !== 16'd0) begin
            n_err++;
            $display("FAIL reset_mid: valid=%b busy=%b freq=%0d, want 0/0/0", a_valid, a_busy, a_freq);
        end
        repeat (2) @(negedge clk);
        // release while the input is low so the synchronizer sees no phantom edge
        guard = 0;
        do begin
            @(negedge clk);
            #1;
            guard++;
        end while (sig !== 1'b0 && guard < 50);
        rst = 1'b0;
        wait_valid(1100, n, ok);
        n_vec++;
        if (!ok || n != 1002 || a_freq !== 16'd100) begin
            n_err++;
            $display("FAIL reset_mid_fresh: got %0d cycles freq=%0d ok=%b, want 1002/100", n, a_freq, ok);
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_sat_recover();
        test_no_activity();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated edge-counting frequency meter for the 100 MHz board clock domain. Counts rising edges of an asynchronous input over a fixed gate window of `GATE_CYCLES` clock cycles and publishes the count with a one-cycle valid strobe. It is the measuring counterpart of the prescaler: the prescaler turns a cycle count into a frequency, and this block turns a frequency back into a count. The display chain consumes the result.

## Interface

Parameters:

- `GATE_CYCLES`, default 100_000_000: gate window length in `i_Clk` cycles (1 s at 100 MHz); ≥ 2.
- `CNT_W`, default 27: width of the edge counter and of `o_Freq`.

Ports:

- `i_Clk`  in  1  system clock, 100 MHz.
- `i_Rst`  in  1  reset, asynchronous, active-high; clears all state.
- `i_En`  in  1  measurement enable; level-sensitive.
- `i_Signal`  in  1  asynchronous signal to measure.
- `o_Freq`  out  CNT_W  edge count of the last completed window.
- `o_Valid`  out  1  one-cycle strobe; `o_Freq` was updated this cycle.
- `o_Busy`  out  1  high while a window is in progress (state ≠ IDLE).
- `o_Ovf`  out  1  the last completed window saturated the counter (see Configuration).

## Operation

- Input path:
  - 2-FF synchronizer on `i_Signal`, plus a third FF holding the previous synchronized value.
  - `edge` = sync & ~prev.
  - Reset value of all three FFs is 0.
- Gate counter: width `$clog2(GATE_CYCLES)`.
- State machine with states IDLE, GATE, LATCH:
  - **IDLE**
    - Gate counter and edge counter held at 0.
    - `i_En`=1 → GATE.
  - **GATE**
    - Gate counter increments every cycle.
    - Edge counter increments on each `edge` and saturates at 2^CNT_W−1.
    - On gate counter == `GATE_CYCLES`−1 → LATCH. An edge in that final cycle is counted.
    - `i_En`=0 in any GATE cycle → IDLE: window aborted, `o_Freq`/`o_Ovf` unchanged, no `o_Valid`.
  - **LATCH**
    - Registers the edge count into `o_Freq`, sets `o_Ovf`, and raises `o_Valid` for the next cycle.
    - `i_En`=1 → GATE with both counters cleared (back-to-back windows). `i_En`=0 → IDLE.
    - An edge in the LATCH cycle is dropped (one dead cycle per window).
- Edges while in IDLE are ignored.
- Input limits:
  - Guaranteed-accurate input: high and low phases each ≥ 2 `i_Clk` periods.
  - Faster inputs undercount; the result is unspecified but never exceeds saturation.
- Width rule: `CNT_W` ≥ `$clog2(GATE_CYCLES/2+1)` gives saturation-free operation within the limits above. Smaller widths are legal and saturate.
- Reset values:
  - `o_Freq`=0, `o_Valid`=0, `o_Busy`=0, `o_Ovf`=0; state IDLE.
  - Assertion mid-window clears everything immediately, with no `o_Valid`.

## Timing

- `i_Signal` rising edge to `edge`: 3 `i_Clk` cycles.
- `i_En` sampled high in IDLE at edge k:
  - GATE occupies cycles k+1 … k+`GATE_CYCLES`.
  - LATCH is at cycle k+`GATE_CYCLES`+1.
  - `o_Valid`=1 and the new `o_Freq` appear in cycle k+`GATE_CYCLES`+2.
- Continuous enable: `o_Valid` period = `GATE_CYCLES`+1 cycles.
- `o_Valid` is always exactly one cycle wide. `o_Freq` is stable between strobes.
- `o_Busy` rises the cycle after `i_En` is sampled in IDLE. It falls the cycle after an abort or after a LATCH with `i_En`=0.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration

- Macro: `FREQ_METER_OVF_EN`.
- Defined: sticky saturation flag, set in GATE when the edge counter is at 2^CNT_W−1 and another edge arrives. Cleared at window start and copied to `o_Ovf` in LATCH.
- Undefined: no flag logic. `o_Ovf` is tied to 0; saturation behaviour of the counter is unchanged. The port exists in both builds.

## Test plan

All scenarios use `GATE_CYCLES`=1000, `CNT_W`=16 unless stated.

- Reset: assert `i_Rst` between clock edges → all outputs 0 immediately. Release with `i_En`=0 → `o_Busy` stays 0.
- Steady measurement: `i_Signal` period 10 clk (5 high / 5 low), `i_En` held 1 → `o_Freq`=100 on every strobe; `o_Valid` 1-cycle pulses spaced exactly 1001 cycles.
- No activity: `i_Signal` constant 1 → `o_Freq`=0, `o_Valid` still pulses every 1001 cycles.
- Abort: after a 100 result, drop `i_En` at gate cycle 500 → no `o_Valid`, `o_Freq` stays 100, `o_Busy`=0 one cycle later. Re-enable → next result 100.
- Saturation: `CNT_W`=4, period 10 clk.
  - With `FREQ_METER_OVF_EN`: `o_Freq`=15, `o_Ovf`=1.
  - Without: `o_Freq`=15, `o_Ovf`=0.
  - Next window at period 200 clk: `o_Freq`=5, `o_Ovf`=0.
- Reset mid-window: assert `i_Rst` at gate cycle 300, hold 2 cycles, release with `i_En`=1 → no strobe until a full fresh window, then `o_Freq`=100.
